// File: rtl/priority_enc_pkg.sv
// Shared helpers for the priority event encoder: index-width calculation.
package priority_enc_pkg;

    // Index width for an N-line encoder, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/priority_event_encoder_prio_sel.sv
// Combinational selector: highest set index (fixed) or first set index after
// start, wrapping modulo N (round-robin).
module prio_sel
    import priority_enc_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = 0,
    localparam int W       = clog2_min1(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [2*N-1:0] dbl;
    logic           found;
    int             first;

    assign dbl = {cand, cand};

    always_comb begin
        idx   = '0;
        any   = |cand;
        found = 1'b0;
        first = (int'(start) + 1) % N;
        if (RR_MODE == 0) begin
            for (int i = 0; i < N; i++)
                if (cand[i]) idx = W'(i);
        end else begin
            // Doubled vector lets the search run past N-1 without explicit wrap logic.
            for (int i = 0; i < N; i++) begin
                if (!found && dbl[first + i]) begin
                    idx   = W'((first + i) % N);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/priority_event_encoder.sv
// Registered N-line priority encoder: event capture into pending latches,
// selection of one pending index and a valid/ready output register.
module priority_event_encoder
    import priority_enc_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = 0,
    parameter  int EDGE    = 1,
    localparam int W       = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] e,
    input  logic         en,
    input  logic         clr_all,
    output logic [W-1:0] s,
    output logic         s_valid,
    input  logic         s_ready,
    output logic [N-1:0] pend,
    output logic         busy,
    output logic         overrun
);

    logic [N-1:0] e_d;
    logic [N-1:0] cap;
    logic [N-1:0] clr_mask;
    logic [N-1:0] cand;
    logic [W-1:0] rr_ptr;
    logic [W-1:0] sel_idx;
    logic         sel_any;
    logic         accept;
    logic         load;

    assign accept   = s_valid & s_ready;
    assign clr_mask = accept ? (N'(1) << s) : '0;
    assign cap      = ((EDGE != 0) ? (e & ~e_d) : e) & {N{en}};
    assign cand     = pend & ~clr_mask;
    assign load     = ~s_valid | s_ready;
    assign busy     = |pend;

    prio_sel #(
        .N       (N),
        .RR_MODE (RR_MODE)
    ) u_sel (
        .cand  (cand),
        .start (rr_ptr),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_d     <= '0;
            pend    <= '0;
            s       <= '0;
            s_valid <= 1'b0;
            overrun <= 1'b0;
            rr_ptr  <= W'(N - 1);
        end else begin
            e_d <= e;
            if (clr_all) begin
                pend    <= '0;
                s_valid <= 1'b0;
                overrun <= 1'b0;
            end else begin
                // A capture on the bit being accepted wins, keeping it pending.
                pend <= cand | cap;
                if (|(cap & cand)) overrun <= 1'b1;
                if (accept) rr_ptr <= s;
                if (load) begin
                    s_valid <= sel_any;
                    if (sel_any) s <= sel_idx;
                end
            end
        end
    end

endmodule
